// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Issue/retire wrapper around the DSP48-based ALU. Decoded ALU ops are
//   accepted through a valid/ready handshake and translated into DSP
//   opmode/alumode/setinst controls, then registered into the DSP. A tag
//   pipeline matched to the DSP latency carries each op's destination to
//   writeback. A small carry register file plus a pending scoreboard makes
//   ADDC wait until the carry it consumes has been written back; there is
//   no carry forwarding.
module alu_issue_stage #(
  parameter int DATA_W   = 16,
  parameter int RD_W     = 11,
  parameter int CARRY_AW = 2,
  parameter int LATENCY  = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  // decoded op from upstream
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_funct,
  input  logic [DATA_W-1:0]   in_rs1,
  input  logic [DATA_W-1:0]   in_rs2,
  input  logic [RD_W-1:0]     in_rd,
  input  logic [CARRY_AW-1:0] in_cs,
  input  logic [CARRY_AW-1:0] in_cd,
  // DSP issue side
  output logic [DATA_W-1:0]   alu_in0,
  output logic [DATA_W-1:0]   alu_in1,
  output logic                alu_carryin,
  output logic [8:0]          alu_opmode,
  output logic [3:0]          alu_alumode,
  output logic [1:0]          alu_setinst,
  output logic                alu_valid_in,
  // DSP result side
  input  logic [DATA_W-1:0]   alu_out,
  input  logic                alu_carryout,
  input  logic                alu_valid_out,
  // writeback
  output logic                wb_valid,
  output logic [RD_W-1:0]     wb_rd,
  output logic [DATA_W-1:0]   wb_data,
  // sticky error flags
  output logic                err_illegal,
  output logic                err_sync
);

  localparam int DEPTH  = LATENCY + 1;
  localparam int NCARRY = 1 << CARRY_AW;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  localparam logic [3:0] F_AND  = 4'd0;
  localparam logic [3:0] F_OR   = 4'd1;
  localparam logic [3:0] F_XOR  = 4'd2;
  localparam logic [3:0] F_ADD  = 4'd3;
  localparam logic [3:0] F_ADDC = 4'd4;
  localparam logic [3:0] F_SUB  = 4'd5;
  localparam logic [3:0] F_SEQ  = 4'd6;
  localparam logic [3:0] F_SLTU = 4'd7;
  localparam logic [3:0] F_SLTS = 4'd8;

  // X:Y = A:B and Z = C path; OR additionally routes the logic unit's
  // second operand so that alumode 1100 yields OR instead of AND.
  localparam logic [8:0] OPM_XY = 9'b000110011;
  localparam logic [8:0] OPM_OR = 9'b000111011;

  localparam logic [3:0] ALU_LOGIC = 4'b1100;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0011;

  typedef struct packed {
    logic       legal;
    logic       wcarry;
    logic       use_cin;
    logic [8:0] opmode;
    logic [3:0] alumode;
    logic [1:0] setinst;
  } ctrl_t;

  // Translate a funct code into the DSP control word; illegal codes
  // decode to an all-zero word with legal cleared.
  function automatic ctrl_t decode_funct(input logic [3:0] funct);
    ctrl_t c;
    c         = '0;
    c.legal   = 1'b1;
    c.opmode  = OPM_XY;
    case (funct)
      F_AND:  c.alumode = ALU_LOGIC;
      F_OR: begin
        c.opmode  = OPM_OR;
        c.alumode = ALU_LOGIC;
      end
      F_XOR:  c.alumode = ALU_XOR;
      F_ADD: begin
        c.alumode = ALU_ADD;
        c.wcarry  = 1'b1;
      end
      F_ADDC: begin
        c.alumode = ALU_ADD;
        c.wcarry  = 1'b1;
        c.use_cin = 1'b1;
      end
      F_SUB: begin
        c.alumode = ALU_SUB;
        c.setinst = 2'b00;
      end
      F_SEQ: begin
        c.alumode = ALU_SUB;
        c.setinst = 2'b01;
      end
      F_SLTU: begin
        c.alumode = ALU_SUB;
        c.setinst = 2'b10;
      end
      F_SLTS: begin
        c.alumode = ALU_SUB;
        c.setinst = 2'b11;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  ctrl_t               dec;
  logic                hazard;
  logic                accept;
  logic                issue;

  logic [NCARRY-1:0]   carry_q;
  logic [NCARRY-1:0]   pending_q;
  logic [NCARRY-1:0]   pending_nxt;

  logic [DATA_W-1:0]   in0_p0;
  logic [DATA_W-1:0]   in1_p0;
  logic                cin_p0;
  logic [8:0]          opmode_p0;
  logic [3:0]          alumode_p0;
  logic [1:0]          setinst_p0;
  logic                vld_p0;

  logic                tag_vld_p [DEPTH];
  logic [RD_W-1:0]     tag_rd_p  [DEPTH];
  logic [CARRY_AW-1:0] tag_cd_p  [DEPTH];
  logic                tag_wc_p  [DEPTH];

  logic                head_vld;
  logic [RD_W-1:0]     head_rd;
  logic [CARRY_AW-1:0] head_cd;
  logic                head_wc;
  logic                retire_carry;

  logic [CNT_W-1:0]    settle_q;
  logic                sync_armed;

  // ---- accept stage: decode, carry hazard and handshake ----
  assign dec    = decode_funct(in_funct);
  assign hazard = (in_funct == F_ADDC) && pending_q[in_cs];
  // Held low during reset so every output reads 0 while reset_n is low.
  assign in_ready = reset_n && !hazard;
  assign accept   = in_valid && in_ready;
  // Illegal ops are consumed (accepted) but never reach the DSP.
  assign issue    = accept && dec.legal;

  // Issue register: one DSP op per accepted legal op, all-zero otherwise
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in0_p0     <= '0;
      in1_p0     <= '0;
      cin_p0     <= 1'b0;
      opmode_p0  <= '0;
      alumode_p0 <= '0;
      setinst_p0 <= '0;
      vld_p0     <= 1'b0;
    end else if (issue) begin
      in0_p0     <= in_rs1;
      in1_p0     <= in_rs2;
      cin_p0     <= dec.use_cin ? carry_q[in_cs] : 1'b0;
      opmode_p0  <= dec.opmode;
      alumode_p0 <= dec.alumode;
      setinst_p0 <= dec.setinst;
      vld_p0     <= 1'b1;
    end else begin
      in0_p0     <= '0;
      in1_p0     <= '0;
      cin_p0     <= 1'b0;
      opmode_p0  <= '0;
      alumode_p0 <= '0;
      setinst_p0 <= '0;
      vld_p0     <= 1'b0;
    end
  end

  // ---- p0: operands and controls presented to the DSP ----
  assign alu_in0      = in0_p0;
  assign alu_in1      = in1_p0;
  assign alu_carryin  = cin_p0;
  assign alu_opmode   = opmode_p0;
  assign alu_alumode  = alumode_p0;
  assign alu_setinst  = setinst_p0;
  assign alu_valid_in = vld_p0;

  // Tag pipeline: entry 0 aligns with the issue register, the last entry
  // with the DSP result; reset discards everything in flight
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_vld_p[i] <= 1'b0;
        tag_rd_p[i]  <= '0;
        tag_cd_p[i]  <= '0;
        tag_wc_p[i]  <= 1'b0;
      end
    end else begin
      tag_vld_p[0] <= issue;
      tag_rd_p[0]  <= issue ? in_rd : '0;
      tag_cd_p[0]  <= issue ? in_cd : '0;
      tag_wc_p[0]  <= issue && dec.wcarry;
      for (int i = 1; i < DEPTH; i++) begin
        tag_vld_p[i] <= tag_vld_p[i-1];
        tag_rd_p[i]  <= tag_rd_p[i-1];
        tag_cd_p[i]  <= tag_cd_p[i-1];
        tag_wc_p[i]  <= tag_wc_p[i-1];
      end
    end
  end

  // ---- retire stage: head of the tag pipeline meets the DSP result ----
  assign head_vld     = tag_vld_p[LATENCY];
  assign head_rd      = tag_rd_p[LATENCY];
  assign head_cd      = tag_cd_p[LATENCY];
  assign head_wc      = tag_wc_p[LATENCY];
  assign retire_carry = head_vld && head_wc;

  assign wb_valid = head_vld;
  assign wb_rd    = head_rd;
  // Result passes straight through from the DSP; forced to 0 when nothing
  // retires so the port is quiet (and 0 throughout reset).
  assign wb_data  = head_vld ? alu_out : '0;

  // Scoreboard update: a new producer's set beats a retiring clear
  always_comb begin
    pending_nxt = pending_q;
    if (retire_carry) begin
      pending_nxt[head_cd] = 1'b0;
    end
    if (issue && dec.wcarry) begin
      pending_nxt[in_cd] = 1'b1;
    end
  end

  // Carry register file and pending bits; carries are written at retire
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      carry_q   <= '0;
      pending_q <= '0;
    end else begin
      if (retire_carry) begin
        carry_q[head_cd] <= alu_carryout;
      end
      pending_q <= pending_nxt;
    end
  end

  // Settle counter: masks the sync check while the DSP may still flush
  // results issued before reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      settle_q <= '0;
    end else if (!sync_armed) begin
      settle_q <= settle_q + CNT_W'(1);
    end
  end

  assign sync_armed = (settle_q == CNT_W'(DEPTH));

  // Sticky error flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_illegal <= 1'b0;
      err_sync    <= 1'b0;
    end else begin
      if (accept && !dec.legal) begin
        err_illegal <= 1'b1;
      end
      if (sync_armed && (alu_valid_out != head_vld)) begin
        err_sync <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage
//   Drives directed and random ALU ops into alu_issue_stage, emulates the
//   two-cycle DSP from its control outputs, and checks every cycle against
//   a behavioural model that computes results directly from the funct code.
module tb_alu_issue_stage;

  localparam int DATA_W   = 16;
  localparam int RD_W     = 11;
  localparam int CARRY_AW = 2;
  localparam int LATENCY  = 2;
  localparam int NC       = 1 << CARRY_AW;

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic                in_valid;
  logic                in_ready;
  logic [3:0]          in_funct;
  logic [DATA_W-1:0]   in_rs1, in_rs2;
  logic [RD_W-1:0]     in_rd;
  logic [CARRY_AW-1:0] in_cs, in_cd;
  logic [DATA_W-1:0]   alu_in0, alu_in1;
  logic                alu_carryin;
  logic [8:0]          alu_opmode;
  logic [3:0]          alu_alumode;
  logic [1:0]          alu_setinst;
  logic                alu_valid_in;
  logic [DATA_W-1:0]   alu_out;
  logic                alu_carryout, alu_valid_out;
  logic                wb_valid;
  logic [RD_W-1:0]     wb_rd;
  logic [DATA_W-1:0]   wb_data;
  logic                err_illegal, err_sync;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clock = ~clock;

  alu_issue_stage #(
    .DATA_W(DATA_W), .RD_W(RD_W), .CARRY_AW(CARRY_AW), .LATENCY(LATENCY)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct(in_funct),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_cs(in_cs), .in_cd(in_cd),
    .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_carryin(alu_carryin),
    .alu_opmode(alu_opmode), .alu_alumode(alu_alumode), .alu_setinst(alu_setinst),
    .alu_valid_in(alu_valid_in),
    .alu_out(alu_out), .alu_carryout(alu_carryout), .alu_valid_out(alu_valid_out),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .err_illegal(err_illegal), .err_sync(err_sync)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- DSP emulation (two register stages) ----------------
  function automatic logic [DATA_W:0] dsp_calc(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                               input logic ci, input logic [8:0] opm,
                                               input logic [3:0] alum, input logic [1:0] si);
    logic [DATA_W:0] r;
    r = '0;
    case (alum)
      4'b1100: r[DATA_W-1:0] = (opm == 9'b000111011) ? (a | b) : (a & b);
      4'b0100: r[DATA_W-1:0] = a ^ b;
      4'b0000: r = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, ci};
      4'b0011: begin
        case (si)
          2'b00:   r[DATA_W-1:0] = a - b;
          2'b01:   r[0] = (a == b);
          2'b10:   r[0] = (a < b);
          default: r[0] = ($signed(a) < $signed(b));
        endcase
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [DATA_W-1:0] d1_out = '0, d2_out = '0;
  logic              d1_c = 1'b0, d2_c = 1'b0, d1_v = 1'b0, d2_v = 1'b0;

  always @(posedge clock) begin
    {d1_c, d1_out} <= dsp_calc(alu_in0, alu_in1, alu_carryin, alu_opmode, alu_alumode, alu_setinst);
    d1_v   <= alu_valid_in;
    d2_out <= d1_out;
    d2_c   <= d1_c;
    d2_v   <= d1_v;
  end

  assign alu_out       = d2_out;
  assign alu_carryout  = d2_c;
  assign alu_valid_out = d2_v;

  // ---------------- behavioural reference model ----------------
  typedef struct {
    int                  due;
    logic [RD_W-1:0]     rd;
    logic [DATA_W-1:0]   data;
    logic                wc;
    logic [CARRY_AW-1:0] cd;
    logic                co;
  } ret_t;

  ret_t              rq[$];
  logic [NC-1:0]     m_pend = '0;
  logic [NC-1:0]     m_carry = '0;
  logic              m_err_ill = 1'b0;
  logic              m_iv = 1'b0;
  logic [47:0]       m_iss = '0;   // {in0, in1, carryin, opmode, alumode, setinst}

  function automatic logic m_ready();
    return !(in_funct == 4'd4 && m_pend[in_cs]);
  endfunction

  // Model state advances on each rising edge, from the inputs held that cycle
  initial forever begin : model
    ret_t            e;
    logic            acc;
    logic [DATA_W:0] r;
    logic [8:0]      opm;
    logic [3:0]      alum;
    logic [1:0]      si;
    logic            ci;
    @(posedge clock);
    if (!reset_n) begin
      rq.delete();
      m_pend = '0; m_carry = '0; m_err_ill = 1'b0; m_iv = 1'b0; m_iss = '0;
    end else begin
      acc  = in_valid && m_ready();
      m_iv = 1'b0; m_iss = '0;
      if (acc && in_funct > 4'd8) begin
        m_err_ill = 1'b1;
      end else if (acc) begin
        ci = (in_funct == 4'd4) ? m_carry[in_cs] : 1'b0;
        r = '0;
        case (in_funct)
          4'd0: r[DATA_W-1:0] = in_rs1 & in_rs2;
          4'd1: r[DATA_W-1:0] = in_rs1 | in_rs2;
          4'd2: r[DATA_W-1:0] = in_rs1 ^ in_rs2;
          4'd3, 4'd4: r = {1'b0, in_rs1} + {1'b0, in_rs2} + {{DATA_W{1'b0}}, ci};
          4'd5: r[DATA_W-1:0] = in_rs1 - in_rs2;
          4'd6: r[0] = (in_rs1 == in_rs2);
          4'd7: r[0] = (in_rs1 < in_rs2);
          default: r[0] = ($signed(in_rs1) < $signed(in_rs2));
        endcase
        opm  = (in_funct == 4'd1) ? 9'b000111011 : 9'b000110011;
        alum = (in_funct <= 4'd1) ? 4'b1100 : (in_funct == 4'd2) ? 4'b0100 :
               (in_funct <= 4'd4) ? 4'b0000 : 4'b0011;
        si   = (in_funct >= 4'd5) ? 2'(in_funct - 4'd5) : 2'b00;
        m_iv  = 1'b1;
        m_iss = {in_rs1, in_rs2, ci, opm, alum, si};
        e.due = cyc + 1 + LATENCY;
        e.rd = in_rd; e.data = r[DATA_W-1:0]; e.co = r[DATA_W];
        e.wc = (in_funct == 4'd3 || in_funct == 4'd4); e.cd = in_cd;
      end
      if (rq.size() > 0 && rq[0].due == cyc) begin
        if (rq[0].wc) begin
          m_carry[rq[0].cd] = rq[0].co;
          m_pend[rq[0].cd]  = 1'b0;
        end
        void'(rq.pop_front());
      end
      if (acc && in_funct <= 4'd8) begin
        if (e.wc) m_pend[in_cd] = 1'b1;
        rq.push_back(e);
      end
    end
    cyc = cyc + 1;
  end

  // ---------------- per-cycle compare (falling edge) ----------------
  logic [RD_W+DATA_W-1:0] wb_at  [int];
  logic [14:0]            iss_at [int];

  initial forever begin : compare
    logic exp_wv;
    @(negedge clock);
    if (reset_n) begin
      exp_wv = (rq.size() > 0) && (rq[0].due == cyc);
      check("in_ready", 64'(in_ready), 64'(m_ready()));
      check("alu_valid_in", 64'(alu_valid_in), 64'(m_iv));
      check("alu_issue_word",
            64'({alu_in0, alu_in1, alu_carryin, alu_opmode, alu_alumode, alu_setinst}), 64'(m_iss));
      check("wb_valid", 64'(wb_valid), 64'(exp_wv));
      if (exp_wv) begin
        check("wb_rd", 64'(wb_rd), 64'(rq[0].rd));
        check("wb_data", 64'(wb_data), 64'(rq[0].data));
      end
      check("err_illegal", 64'(err_illegal), 64'(m_err_ill));
      check("err_sync", 64'(err_sync), 64'd0);
      if (wb_valid) wb_at[cyc] = {wb_rd, wb_data};
      if (alu_valid_in) iss_at[cyc] = {alu_opmode, alu_alumode, alu_setinst};
    end
  end

  // ---------------- stimulus helpers ----------------
  // Offer an op (caller is just after a rising edge) and hold it until the
  // model says it is taken; returns the accept cycle and stall count.
  task automatic send(input logic [3:0] f, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                      input logic [RD_W-1:0] rd, input logic [CARRY_AW-1:0] cs,
                      input logic [CARRY_AW-1:0] cd, output int acc_cyc, output int stalls);
    in_valid = 1'b1; in_funct = f; in_rs1 = a; in_rs2 = b; in_rd = rd; in_cs = cs; in_cd = cd;
    stalls = 0; acc_cyc = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (m_ready()) begin
        acc_cyc = cyc;
        @(posedge clock); #1;
        break;
      end
      stalls++;
      @(posedge clock); #1;
    end
    if (acc_cyc < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout at cycle %0d: funct %0d never accepted, required acceptance within 40 cycles", cyc, f);
      in_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pin_wb(input string name, input int c, input logic [RD_W-1:0] rd, input logic [DATA_W-1:0] d);
    check(name, 64'({(wb_at.exists(c) != 0), (wb_at.exists(c) != 0) ? wb_at[c] : '0}),
          64'({1'b1, rd, d}));
  endtask

  task automatic pin_iss(input string name, input int c, input logic [14:0] ctrl);
    check(name, 64'({(iss_at.exists(c) != 0), (iss_at.exists(c) != 0) ? iss_at[c] : 15'd0}),
          64'({1'b1, ctrl}));
  endtask

  function automatic logic [DATA_W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return DATA_W'($urandom);
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_alu_word"},
          64'({alu_in0, alu_in1, alu_carryin, alu_opmode, alu_alumode, alu_setinst, alu_valid_in}), 64'd0);
    check({tag, "_wb"}, 64'({wb_valid, wb_rd, wb_data}), 64'd0);
    check({tag, "_err"}, 64'({err_illegal, err_sync}), 64'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog at cycle %0d: simulation did not finish in time", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed and random stimulus ----------------
  initial begin : stim
    int a0, a1, a2, a3, st, st_sum;
    in_valid = 1'b0; in_funct = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_cs = '0; in_cd = '0;
    repeat (3) @(posedge clock);
    #1 check_all_zero("reset");
    #1 reset_n = 1'b1;
    idle(1);

    // AND 0xF0F0 & 0xFF00
    send(4'd0, 16'hF0F0, 16'hFF00, 11'd1, 2'd0, 2'd0, a0, st);
    idle(5);
    pin_iss("and_ctrl", a0 + 1, {9'b000110011, 4'b1100, 2'b00});
    pin_wb("and_wb", a0 + 3, 11'd1, 16'hF000);

    // back-to-back OR, XOR, SUB, SLTS on (0x8000, 0x0001)
    send(4'd1, 16'h8000, 16'h0001, 11'd2, 2'd0, 2'd0, a0, st); st_sum = st;
    send(4'd2, 16'h8000, 16'h0001, 11'd3, 2'd0, 2'd0, a1, st); st_sum += st;
    send(4'd5, 16'h8000, 16'h0001, 11'd4, 2'd0, 2'd0, a2, st); st_sum += st;
    send(4'd8, 16'h8000, 16'h0001, 11'd5, 2'd0, 2'd0, a3, st); st_sum += st;
    idle(6);
    check("b2b_stalls", 64'(st_sum), 64'd0);
    check("b2b_span", 64'(a3 - a0), 64'd3);
    pin_iss("or_ctrl", a0 + 1, {9'b000111011, 4'b1100, 2'b00});
    pin_wb("or_wb", a0 + 3, 11'd2, 16'h8001);
    pin_wb("xor_wb", a0 + 4, 11'd3, 16'h8001);
    pin_wb("sub_wb", a0 + 5, 11'd4, 16'h7FFF);
    pin_wb("slts_wb", a0 + 6, 11'd5, 16'h0001);

    // ADD producing a carry into c2, dependent ADDC offered next cycle
    send(4'd3, 16'hFFFF, 16'h0001, 11'd6, 2'd0, 2'd2, a0, st);
    send(4'd4, 16'h0000, 16'h0000, 11'd7, 2'd2, 2'd0, a1, st);
    idle(6);
    check("addc_stalls", 64'(st), 64'd3);
    check("addc_gap", 64'(a1 - a0), 64'd4);
    pin_wb("add_wb", a0 + 3, 11'd6, 16'h0000);
    pin_wb("addc_wb", a1 + 3, 11'd7, 16'h0001);

    // SEQ equal / unequal
    send(4'd6, 16'd5, 16'd5, 11'd8, 2'd0, 2'd0, a0, st);
    send(4'd6, 16'd5, 16'd4, 11'd9, 2'd0, 2'd0, a1, st);
    idle(5);
    pin_iss("seq_ctrl", a0 + 1, {9'b000110011, 4'b0011, 2'b01});
    pin_wb("seq_eq_wb", a0 + 3, 11'd8, 16'h0001);
    pin_wb("seq_ne_wb", a1 + 3, 11'd9, 16'h0000);

    // illegal funct is swallowed, later ops unaffected
    send(4'd12, 16'h1234, 16'h5678, 11'd10, 2'd0, 2'd0, a0, st);
    send(4'd0, 16'h00FF, 16'h0F0F, 11'd11, 2'd0, 2'd0, a1, st);
    idle(5);
    check("illegal_flag", 64'(err_illegal), 64'd1);
    check("illegal_no_issue", 64'(iss_at.exists(a0 + 1)), 64'd0);
    check("illegal_no_wb", 64'(wb_at.exists(a0 + 3)), 64'd0);
    pin_wb("after_illegal_wb", a1 + 3, 11'd11, 16'h000F);

    // random traffic with carry chains, gaps and occasional illegal codes
    for (int n = 0; n < 300; n++) begin
      logic [3:0] f;
      f = ($urandom_range(0, 19) == 0) ? 4'(9 + $urandom_range(0, 6)) : 4'($urandom_range(0, 8));
      send(f, pick(), pick(), RD_W'($urandom), CARRY_AW'($urandom), CARRY_AW'($urandom), a0, st);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(6);

    // reset with two ops in flight and c1 pending
    send(4'd3, 16'hFFFF, 16'h0001, 11'd20, 2'd0, 2'd1, a0, st);
    send(4'd0, 16'hFFFF, 16'h00FF, 11'd21, 2'd0, 2'd0, a1, st);
    in_valid = 1'b0;
    #3 reset_n = 1'b0;
    #1 check_all_zero("inflight_reset");
    @(posedge clock);
    #2 reset_n = 1'b1;
    send(4'd4, 16'd5, 16'd6, 11'd22, 2'd1, 2'd3, a2, st);
    idle(6);
    check("post_reset_addc_stalls", 64'(st), 64'd0);
    check("post_reset_no_wb", 64'(wb_at.exists(a0 + 3) || wb_at.exists(a1 + 3)), 64'd0);
    pin_wb("post_reset_addc_wb", a2 + 3, 11'd22, 16'd11);
    check("post_reset_err_sync", 64'(err_sync), 64'd0);

    // a little more random traffic after reset
    for (int n = 0; n < 60; n++) begin
      send(4'($urandom_range(0, 8)), pick(), pick(), RD_W'($urandom), CARRY_AW'($urandom),
           CARRY_AW'($urandom), a0, st);
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Issue stage that sits directly upstream of the DSP48-based ALU (AluDsp48) and also collects its results.
- Accepts decoded ALU ops through a valid/ready handshake, translates each funct code into the DSP opmode/alumode/setinst controls, and registers operands into the DSP.
- Tracks in-flight destinations in a tag pipeline matched to the DSP latency.
- Retires results to writeback, and keeps a small carry register file with a scoreboard so ADDC chains stall correctly.

Parameters:
- DATA_W, 16, operand/result width.
- RD_W, 11, destination register address width.
- CARRY_AW, 2, carry register address width (2**CARRY_AW carry registers).
- LATENCY, 2, DSP cycles from alu_valid_in to alu_valid_out.

Ports:
- clock, input, 1, single clock; all state on rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, op offered.
- in_ready, output, 1, op can be accepted this cycle.
- in_funct, input, 4, 0 AND, 1 OR, 2 XOR, 3 ADD, 4 ADDC, 5 SUB, 6 SEQ, 7 SLTU, 8 SLTS; 9-15 illegal.
- in_rs1, input, DATA_W, operand 0.
- in_rs2, input, DATA_W, operand 1.
- in_rd, input, RD_W, destination register.
- in_cs, input, CARRY_AW, carry source (ADDC only).
- in_cd, input, CARRY_AW, carry destination (ADD/ADDC only).
- alu_in0, output, DATA_W, DSP operand 0.
- alu_in1, output, DATA_W, DSP operand 1.
- alu_carryin, output, 1, DSP carry in.
- alu_opmode, output, 9, DSP opmode.
- alu_alumode, output, 4, DSP alumode.
- alu_setinst, output, 2, DSP set-compare select.
- alu_valid_in, output, 1, DSP op valid.
- alu_out, input, DATA_W, DSP result.
- alu_carryout, input, 1, DSP carry out.
- alu_valid_out, input, 1, DSP result valid.
- wb_valid, output, 1, retire strobe.
- wb_rd, output, RD_W, retiring destination.
- wb_data, output, DATA_W, retiring result.
- err_illegal, output, 1, sticky: illegal funct accepted.
- err_sync, output, 1, sticky: alu_valid_out disagreed with tag pipeline.

Behaviour:
- Reset (async assert, sync release):
  - All outputs go to 0.
  - Carry registers, pending bits and the tag pipeline are cleared.
  - err flags are cleared.
  - Ops in flight at reset are discarded; no wb_valid is produced for them.
- Decode, as opmode/alumode/setinst:
  - AND: 000110011 / 1100 / 00
  - OR: 000111011 / 1100 / 00
  - XOR: 000110011 / 0100 / 00
  - ADD: 000110011 / 0000 / 00
  - ADDC: 000110011 / 0000 / 00
  - SUB, SEQ, SLTU, SLTS: 000110011 / 0011 / setinst 00, 01, 10, 11 respectively
- Carry in:
  - alu_carryin = carry[in_cs] for ADDC.
  - alu_carryin = 0 for all other functs.
- Handshake:
  - Accept when in_valid && in_ready.
  - in_ready = !(funct==ADDC && pending[in_cs]). It depends combinationally on in_funct/in_cs; upstream must hold its offer stable while in_valid is high and in_ready is low.
- Issue register:
  - An op accepted in cycle t drives alu_* with alu_valid_in=1 in cycle t+1.
  - With no accept, alu_valid_in=0 and the operands/controls are driven to 0.
- Illegal funct:
  - The op is accepted, err_illegal is set, and the op is dropped.
  - alu_valid_in stays 0 and no tag is pushed.
- Tag pipeline:
  - Depth LATENCY+1; each entry holds {valid, rd, cd, wcarry}.
  - wcarry=1 for ADD/ADDC.
- Retire at cycle t+1+LATENCY (t+3 by default):
  - wb_valid = head.valid.
  - wb_rd = head.rd.
  - wb_data = alu_out. This path is combinational from the DSP.
  - If head.wcarry is set, carry[head.cd] <= alu_carryout at the end of that cycle, and pending[head.cd] is cleared.
- Scoreboard:
  - On accepting ADD/ADDC, pending[in_cd] is set.
  - When a set and a clear hit the same bit in the same cycle, the set wins.
- Dependency timing: no carry forwarding. An ADDC depending on an op accepted at t is accepted at t+4 at the earliest.
- Sync check:
  - If alu_valid_out != head.valid, err_sync is set.
  - The check is masked for the first LATENCY+1 cycles after reset release.
- Throughput: one op per cycle when there is no carry hazard. A stall does not disturb ops already in flight.

Test Plan:
- Reset, then issue AND rs1=0xF0F0, rs2=0xFF00 at cycle 0 -> alu_valid_in=1, alu_opmode=000110011, alu_alumode=1100 at cycle 1; wb_valid=1, wb_data=0xF000 at cycle 3.
- Back-to-back OR, XOR, SUB, SLTS for (0x8000, 0x0001) -> one retire per cycle, in order, data 0x8001, 0x8001, 0x7FFF, 0x0001; wb_rd matches the issue order; in_ready stays high.
- ADD 0xFFFF+0x0001 with cd=2, then ADDC 0x0000+0x0000 with cs=2 offered in the next cycle -> in_ready=0 for 3 cycles; ADDC is accepted 4 cycles after the ADD and retires wb_data=0x0001.
- SEQ (5,5) then SEQ (5,4) -> alu_setinst=01; retire data 0x0001 then 0x0000.
- in_funct=12 accepted -> err_illegal=1; no alu_valid_in and no wb_valid; subsequent legal ops are unaffected.
- Assert reset_n low with 2 ops in flight and pending[1] set -> outputs drop to 0 immediately; after release, no wb_valid for those ops, ADDC with cs=1 is accepted at once, and err_sync stays 0.
